// File: rtl/rv32i_wb_unit_if.sv
// rv32i_wb_unit_if: writeback-stage bus bundle.
// Groups the memory-stage inputs, read-data returns and register-file/forwarding outputs.
// slave modport: the writeback unit; master modport: whatever drives it (pipeline or bench).
interface rv32i_wb_unit_if #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
);
   logic              valid_in;
   logic              wb_en_in;
   logic [REG_AW-1:0] wb_reg_in;
   logic [XLEN-1:0]   pc_in;
   logic [XLEN-1:0]   iw_in;
   logic [XLEN-1:0]   alu_in;
   logic [1:0]        src_sel_in;
   logic [XLEN-1:0]   mem_rdata;
   logic [XLEN-1:0]   io_rdata;
   logic              mem_rvalid;
   logic              io_rvalid;
   logic              stall_out;
   logic              wb_en_out;
   logic [REG_AW-1:0] wb_reg_out;
   logic [XLEN-1:0]   wb_data;
   logic              df_wb_enable;
   logic [REG_AW-1:0] df_wb_reg;
   logic [XLEN-1:0]   df_wb_data;
   logic              err_timeout;
   logic [63:0]       retire_cnt;
   modport slave (
      input  valid_in, wb_en_in, wb_reg_in, pc_in, iw_in, alu_in, src_sel_in,
             mem_rdata, io_rdata, mem_rvalid, io_rvalid,
      output stall_out, wb_en_out, wb_reg_out, wb_data,
             df_wb_enable, df_wb_reg, df_wb_data, err_timeout, retire_cnt
   );
   modport master (
      output valid_in, wb_en_in, wb_reg_in, pc_in, iw_in, alu_in, src_sel_in,
             mem_rdata, io_rdata, mem_rvalid, io_rvalid,
      input  stall_out, wb_en_out, wb_reg_out, wb_data,
             df_wb_enable, df_wb_reg, df_wb_data, err_timeout, retire_cnt
   );
endinterface

// File: rtl/rv32i_wb_unit.sv
// rv32i_wb_unit: RV32I writeback stage with source select, load formatting and bounded read wait.
// Ports: clk, reset (sync, active-high), bus (rv32i_wb_unit_if.slave) carrying the memory-stage
// instruction, mem/io read returns, stall_out, the registered register-file write port, its
// forwarding copies (df_*), err_timeout and retire_cnt.
// Optional: define WB_RETIRE_CNT_EN to build the 64-bit retired-instruction counter;
// otherwise retire_cnt is tied to 0.
module rv32i_wb_unit #(
   parameter int XLEN     = 32,
   parameter int REG_AW   = 5,
   parameter int WAIT_MAX = 15
) (
   input logic             clk,
   input logic             reset,
   rv32i_wb_unit_if.slave  bus
);
   localparam int CW = $clog2(WAIT_MAX + 1);
   localparam logic [CW-1:0] LAST = CW'(WAIT_MAX - 1);
   typedef enum logic {IDLE, WAIT} state_t;
   state_t            state;
   logic [CW-1:0]     cnt;
   logic              h_en;
   logic [REG_AW-1:0] h_reg;
   logic [1:0]        h_src;
   logic [2:0]        h_f3;
   logic [1:0]        h_off;
   logic              c_en, match, is_rd, accept, commit, go_wait, timeout, in_wait;
   logic [REG_AW-1:0] c_reg;
   logic [1:0]        c_src, c_off;
   logic [2:0]        c_f3;
   logic [7:0]        b;
   logic [15:0]       h;
   logic [XLEN-1:0]   ld, data;
   logic              wb_en_q, err_q;
   logic [REG_AW-1:0] wb_reg_q;
   logic [XLEN-1:0]   wb_data_q;
   logic              unused_iw;
   assign unused_iw = ^{bus.iw_in[31:15], bus.iw_in[11:0]};
   // In WAIT the held instruction is used; upstream inputs are don't-care.
   always_comb begin
      in_wait = state == WAIT;
      c_en    = in_wait ? h_en  : bus.wb_en_in;
      c_reg   = in_wait ? h_reg : bus.wb_reg_in;
      c_src   = in_wait ? h_src : bus.src_sel_in;
      c_f3    = in_wait ? h_f3  : bus.iw_in[14:12];
      c_off   = in_wait ? h_off : bus.alu_in[1:0];
      match   = c_src == 2'd1 ? bus.mem_rvalid : c_src == 2'd2 ? bus.io_rvalid : 1'b0;
      is_rd   = c_src[0] ^ c_src[1];
      accept  = !in_wait && bus.valid_in;
      commit  = (accept && (!is_rd || match)) || (in_wait && match);
      go_wait = accept && is_rd && !match;
      // Data arriving in the last allowed cycle beats the timeout.
      timeout = in_wait && !match && cnt == LAST;
      b       = bus.mem_rdata[{c_off, 3'b000} +: 8];
      h       = c_off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
      ld      = c_f3 == 3'b000 ? {{(XLEN-8){b[7]}}, b} :
                c_f3 == 3'b100 ? {{(XLEN-8){1'b0}}, b} :
                c_f3 == 3'b001 ? {{(XLEN-16){h[15]}}, h} :
                c_f3 == 3'b101 ? {{(XLEN-16){1'b0}}, h} :
                c_f3 == 3'b010 ? bus.mem_rdata : '0;
      data    = c_src == 2'd0 ? bus.alu_in : c_src == 2'd1 ? ld :
                c_src == 2'd2 ? bus.io_rdata : bus.pc_in + XLEN'(4);
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         wb_en_q   <= 1'b0;
         wb_reg_q  <= '0;
         wb_data_q <= '0;
         err_q     <= 1'b0;
      end else begin
         err_q   <= timeout;
         wb_en_q <= commit && c_en && c_reg != '0;
         if (commit) begin
            wb_reg_q  <= c_reg;
            wb_data_q <= data;
         end
         if (go_wait) begin
            state <= WAIT;
            cnt   <= '0;
            h_en  <= bus.wb_en_in;
            h_reg <= bus.wb_reg_in;
            h_src <= bus.src_sel_in;
            h_f3  <= bus.iw_in[14:12];
            h_off <= bus.alu_in[1:0];
         end else if (in_wait) begin
            cnt <= cnt + 1'b1;
            if (match || timeout) state <= IDLE;
         end
      end
   end
`ifdef WB_RETIRE_CNT_EN
   logic [63:0] rc;
   always_ff @(posedge clk) begin
      if (reset) rc <= '0;
      else if (commit) rc <= rc + 64'd1;
   end
   assign bus.retire_cnt = rc;
`else
   assign bus.retire_cnt = '0;
`endif
   assign bus.stall_out    = !reset && (in_wait || go_wait);
   assign bus.wb_en_out    = wb_en_q;
   assign bus.wb_reg_out   = wb_reg_q;
   assign bus.wb_data      = wb_data_q;
   assign bus.df_wb_enable = wb_en_q;
   assign bus.df_wb_reg    = wb_reg_q;
   assign bus.df_wb_data   = wb_data_q;
   assign bus.err_timeout  = err_q;
endmodule

// File: tb/tb_rv32i_wb_unit.sv
// tb_rv32i_wb_unit: self-checking bench for rv32i_wb_unit (vector table + corner sequences).
module tb_rv32i_wb_unit;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int checks = 0;
   int errors = 0;
   longint unsigned exp_rc = 0;
   always #5 clk = ~clk;
   rv32i_wb_unit_if #(.XLEN(32), .REG_AW(5)) bus ();
   rv32i_wb_unit #(.XLEN(32), .REG_AW(5), .WAIT_MAX(4)) dut (.clk(clk), .reset(reset), .bus(bus));
   typedef struct {
      logic v, en; logic [4:0] rg; logic [1:0] src; logic [2:0] f3;
      logic [31:0] alu, pc, md; logic mv; logic [31:0] id; logic iv;
      logic e_stall, e_en; logic [31:0] e_data; logic chk;
   } vec_t;
   typedef struct { logic en; logic [4:0] rg; logic [31:0] data; logic chk; } exp_t;
   exp_t q[$];
   vec_t vt[16];
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   function automatic logic [63:0] rc_exp();
`ifdef WB_RETIRE_CNT_EN
      return exp_rc;
`else
      return 64'd0;
`endif
   endfunction
   task automatic drive(input logic v, input logic en, input logic [4:0] rg, input logic [1:0] src,
                        input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc);
      bus.valid_in = v; bus.wb_en_in = en; bus.wb_reg_in = rg; bus.src_sel_in = src;
      bus.iw_in = {17'h0, f3, 12'h003}; bus.alu_in = alu; bus.pc_in = pc;
   endtask
   task automatic idle();
      drive(1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0);
      bus.mem_rvalid = 1'b0; bus.io_rvalid = 1'b0;
   endtask
   task automatic outs_zero(input string tag);
      chk({tag, " wb_en_out"}, bus.wb_en_out, 0);
      chk({tag, " wb_reg_out"}, bus.wb_reg_out, 0);
      chk({tag, " wb_data"}, bus.wb_data, 0);
      chk({tag, " err_timeout"}, bus.err_timeout, 0);
      chk({tag, " retire_cnt"}, bus.retire_cnt, 0);
   endtask
   initial begin
      exp_t e;
      int n, w;
      bit seen;
      vt[0]  = '{1,1,5,0,3'b000,32'h1234,0,0,0,0,0,0,1,32'h1234,1};
      vt[1]  = '{1,1,7,1,3'b000,32'h1003,0,32'h80FFFF00,1,0,0,0,1,32'hFFFFFF80,1};
      vt[2]  = '{1,1,7,1,3'b100,32'h1003,0,32'h80FFFF00,1,0,0,0,1,32'h00000080,1};
      vt[3]  = '{1,1,7,1,3'b001,32'h1002,0,32'h80FFFF00,1,0,0,0,1,32'hFFFF80FF,1};
      vt[4]  = '{1,1,7,1,3'b101,32'h1003,0,32'h80FFFF00,1,0,0,0,1,32'h000080FF,1};
      vt[5]  = '{1,1,7,1,3'b010,32'h1001,0,32'h80FFFF00,1,0,0,0,1,32'h80FFFF00,1};
      vt[6]  = '{1,1,7,1,3'b000,32'h1001,0,32'h80FFFF00,1,0,0,0,1,32'hFFFFFFFF,1};
      vt[7]  = '{1,1,7,1,3'b011,32'h1000,0,32'h80FFFF00,1,0,0,0,1,32'h0,1};
      vt[8]  = '{1,1,6,2,3'b000,32'h1001,0,32'h11111111,1,32'hDEADBEEF,1,0,1,32'hDEADBEEF,1};
      vt[9]  = '{1,1,0,3,3'b000,32'h0,32'h100,0,0,0,0,0,0,32'h104,1};
      vt[10] = '{1,1,1,3,3'b000,32'h0,32'h100,0,0,0,0,0,1,32'h104,1};
      vt[11] = '{1,0,3,0,3'b000,32'h55,0,0,0,0,0,0,0,32'h55,1};
      vt[12] = '{1,1,2,3,3'b000,32'h0,32'hFFFFFFFC,0,0,0,0,0,1,32'h0,1};
      vt[13] = '{0,1,4,0,3'b000,32'h99,0,0,0,0,0,0,0,32'h0,0};
      vt[14] = '{1,1,8,0,3'b000,32'hA,0,0,0,0,0,0,1,32'hA,1};
      vt[15] = '{1,1,9,0,3'b000,32'hB,0,0,0,0,0,0,1,32'hB,1};
      bus.mem_rdata = 0; bus.io_rdata = 0;
      idle();
      drive(1'b1, 1'b1, 5'd3, 2'd1, 3'd0, 32'h0, 32'h0);
      #1;
      chk("stall in reset", bus.stall_out, 0);
      tick(); tick();
      outs_zero("reset");
      chk("df_wb_enable reset", bus.df_wb_enable, 0);
      reset = 1'b0;
      idle();
      for (int i = 0; i < 16; i++) begin
         drive(vt[i].v, vt[i].en, vt[i].rg, vt[i].src, vt[i].f3, vt[i].alu, vt[i].pc);
         bus.mem_rdata = vt[i].md; bus.mem_rvalid = vt[i].mv;
         bus.io_rdata = vt[i].id; bus.io_rvalid = vt[i].iv;
         #1;
         chk($sformatf("vec%0d stall", i), bus.stall_out, vt[i].e_stall);
         q.push_back('{vt[i].e_en, vt[i].rg, vt[i].e_data, vt[i].chk});
         if (vt[i].v) exp_rc++;
         tick();
         e = q.pop_front();
         chk($sformatf("vec%0d wb_en_out", i), bus.wb_en_out, e.en);
         chk($sformatf("vec%0d df_wb_enable", i), bus.df_wb_enable, e.en);
         if (e.chk) begin
            chk($sformatf("vec%0d wb_reg_out", i), bus.wb_reg_out, e.rg);
            chk($sformatf("vec%0d wb_data", i), bus.wb_data, e.data);
            chk($sformatf("vec%0d df_wb_reg", i), bus.df_wb_reg, e.rg);
            chk($sformatf("vec%0d df_wb_data", i), bus.df_wb_data, e.data);
         end
      end
      idle();
      chk("table retire_cnt", bus.retire_cnt, rc_exp());
      // delayed load: data arrives on the third stalled cycle
      n = 0;
      drive(1'b1, 1'b1, 5'd7, 2'd1, 3'b000, 32'h3, 32'h0);
      bus.mem_rdata = 32'h80FFFF00;
      #1; n += int'(bus.stall_out);
      tick();
      drive(1'b1, 1'b1, 5'd4, 2'd0, 3'b000, 32'h77, 32'h0);
      bus.io_rvalid = 1'b1;
      #1; n += int'(bus.stall_out);
      tick();
      chk("delay no early commit", bus.wb_en_out, 0);
      bus.io_rvalid = 1'b0; bus.mem_rvalid = 1'b1;
      #1; n += int'(bus.stall_out);
      tick();
      idle();
      exp_rc++;
      chk("delay stall cycles", n, 3);
      chk("delay wb_en_out", bus.wb_en_out, 1);
      chk("delay wb_reg_out", bus.wb_reg_out, 7);
      chk("delay wb_data", bus.wb_data, 32'hFFFFFF80);
      chk("delay retire_cnt", bus.retire_cnt, rc_exp());
      #1;
      chk("delay stall released", bus.stall_out, 0);
      // timeout with no read data
      drive(1'b1, 1'b1, 5'd9, 2'd2, 3'b000, 32'h0, 32'h0);
      tick();
      idle();
      w = 0; seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
         w++;
         tick();
         seen = bus.err_timeout;
      end
      chk("timeout seen", seen, 1);
      chk("timeout wait cycles", w, 4);
      chk("timeout wb_en_out", bus.wb_en_out, 0);
      chk("timeout retire_cnt", bus.retire_cnt, rc_exp());
      chk("timeout stall idle", bus.stall_out, 0);
      tick();
      chk("timeout single pulse", bus.err_timeout, 0);
      // read data in the exact timeout cycle wins
      drive(1'b1, 1'b1, 5'd10, 2'd1, 3'b010, 32'h0, 32'h0);
      bus.mem_rdata = 32'hCAFEF00D;
      tick();
      idle();
      tick(); tick(); tick();
      bus.mem_rvalid = 1'b1;
      tick();
      bus.mem_rvalid = 1'b0;
      exp_rc++;
      chk("race wb_en_out", bus.wb_en_out, 1);
      chk("race wb_data", bus.wb_data, 32'hCAFEF00D);
      chk("race no error", bus.err_timeout, 0);
      chk("race retire_cnt", bus.retire_cnt, rc_exp());
      tick();
      chk("race no late error", bus.err_timeout, 0);
      // reset while waiting drops the held instruction
      drive(1'b1, 1'b1, 5'd11, 2'd1, 3'b010, 32'h0, 32'h0);
      tick();
      idle();
      chk("rst-wait stall before", bus.stall_out, 1);
      reset = 1'b1;
      #1;
      chk("rst-wait stall in reset", bus.stall_out, 0);
      tick();
      outs_zero("rst-wait");
      reset = 1'b0;
      bus.mem_rvalid = 1'b1;
      tick();
      bus.mem_rvalid = 1'b0;
      chk("rst-wait late rvalid", bus.wb_en_out, 0);
      chk("rst-wait late stall", bus.stall_out, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
